in_debounce: RTL and testbench

//  Two-channel input conditioner directly upstream of top: drives top.in1/top.in2.

---
 rtl/in_debounce_if.sv | 12 +
 rtl/in_debounce.sv | 93 +++++++++
 tb/tb_in_debounce.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/in_debounce_if.sv
// Raw-pin inputs and debounced outputs/strobes of the two-channel input conditioner.
interface in_debounce_if;
  logic raw1;
  logic raw2;
  logic in1;
  logic in2;
  logic chg1;
  logic chg2;

  modport master (output raw1, raw2, input in1, in2, chg1, chg2);
  modport slave  (input raw1, raw2, output in1, in2, chg1, chg2);
endinterface

// File: rtl/in_debounce.sv
// Two independent channels: synchronize a raw pin, debounce it, and strobe on each accepted change.
module in_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst,
  in_debounce_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned N_CH   = 2;

  typedef enum logic {STABLE, COUNT} state_e;

  logic [N_CH-1:0] raw_w;
  logic [N_CH-1:0] out_w;
  logic [N_CH-1:0] chg_w;

  assign raw_w    = {bus.raw2, bus.raw1};
  assign bus.in1  = out_w[0];
  assign bus.in2  = out_w[1];
  assign bus.chg1 = chg_w[0];
  assign bus.chg2 = chg_w[1];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    state_e                 state_q, state_d;
    logic                   out_q, out_d;
    logic                   chg_q, chg_d;
    logic                   syn;

    assign syn      = sync_q[SYNC_STAGES-1];
    assign out_w[g] = out_q;
    assign chg_w[g] = chg_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        state_q <= STABLE;
        out_q   <= 1'b0;
        chg_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_w[g]};
        cnt_q   <= cnt_d;
        state_q <= state_d;
        out_q   <= out_d;
        chg_q   <= chg_d;
      end
    end

    // A difference must persist DEBOUNCE_CYCLES edges; any return to out restarts from zero.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      chg_d   = 1'b0;
      case (state_q)
        STABLE: begin
          if (syn != out_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              out_d = syn;
              chg_d = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = COUNT;
            end
          end
        end
        COUNT: begin
          if (syn == out_q) begin
            cnt_d   = '0;
            state_d = STABLE;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            out_d   = syn;
            chg_d   = 1'b1;
            cnt_d   = '0;
            state_d = STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = STABLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_in_debounce.sv
// Directed bench for in_debounce: one instance with DEBOUNCE_CYCLES=4, one with DEBOUNCE_CYCLES=1.
module tb_in_debounce;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  in_debounce_if ifa ();
  in_debounce_if ifb ();

  in_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  in_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs set before tick() are sampled by that edge; outputs are read 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rise_at;
    int pulses;
    logic seen;
    logic [3:0] bounce;
    logic [8:0] pat;
    logic hist [0:31];
    logic exp_out, exp_prev;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ifa.raw1 = 1'b0;
    ifa.raw2 = 1'b0;
    ifb.raw1 = 1'b0;
    ifb.raw2 = 1'b0;
    do_reset();

    check_eq("rst_in1", 32'(ifa.in1), 32'd0);
    check_eq("rst_in2", 32'(ifa.in2), 32'd0);
    check_eq("rst_chg1", 32'(ifa.chg1), 32'd0);
    check_eq("rst_chg2", 32'(ifa.chg2), 32'd0);

    // Rise on channel 1: sampled at edge r=1, output at r=6.
    ifa.raw1 = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      tick();
      check_eq("t1_in1_early", 32'(ifa.in1), 32'd0);
    end
    tick();
    check_eq("t1_in1_rise", 32'(ifa.in1), 32'd1);
    check_eq("t1_chg1_rise", 32'(ifa.chg1), 32'd1);
    tick();
    check_eq("t1_chg1_drop", 32'(ifa.chg1), 32'd0);
    check_eq("t1_in1_hold", 32'(ifa.in1), 32'd1);
    check_eq("t1_in2", 32'(ifa.in2), 32'd0);
    check_eq("t1_chg2", 32'(ifa.chg2), 32'd0);

    // Three-cycle pulse is shorter than the debounce window.
    ifa.raw1 = 1'b0;
    do_reset();
    seen = 1'b0;
    for (int r = 1; r <= 14; r++) begin
      ifa.raw1 = (r <= 3);
      tick();
      seen = seen | ifa.chg1 | ifa.in1;
    end
    check_eq("t2_glitch_blocked", 32'(seen), 32'd0);

    // Bouncing channel 2; last 0->1 sampling at r=6, rise expected at r=11.
    pat = 9'b111101101;
    rise_at = 0;
    pulses  = 0;
    seen    = 1'b0;
    for (int r = 1; r <= 18; r++) begin
      ifa.raw2 = (r <= 9) ? pat[r-1] : 1'b1;
      tick();
      if (ifa.chg2) pulses++;
      if (ifa.in2 && rise_at == 0) rise_at = r;
      seen = seen | ifa.in1 | ifa.chg1;
    end
    check_eq("t3_rise_edge", 32'(rise_at), 32'd11);
    check_eq("t3_chg2_pulses", 32'(pulses), 32'd1);
    check_eq("t3_in2_final", 32'(ifa.in2), 32'd1);
    check_eq("t3_ch1_quiet", 32'(seen), 32'd0);

    // Both channels rise on the same edge.
    ifa.raw2 = 1'b0;
    do_reset();
    ifa.raw1 = 1'b1;
    ifa.raw2 = 1'b1;
    for (int r = 1; r <= 5; r++) tick();
    bounce = {ifa.chg2, ifa.chg1, ifa.in2, ifa.in1};
    check_eq("t4_before", 32'(bounce), 32'h0);
    tick();
    bounce = {ifa.chg2, ifa.chg1, ifa.in2, ifa.in1};
    check_eq("t4_both", 32'(bounce), 32'hf);

    // Reset mid-count drops the pending change; resampled from r=5, rise at r=10.
    ifa.raw1 = 1'b0;
    ifa.raw2 = 1'b0;
    do_reset();
    ifa.raw1 = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_rst_in1", 32'(ifa.in1), 32'd0);
    check_eq("t5_rst_chg1", 32'(ifa.chg1), 32'd0);
    seen = 1'b0;
    for (int r = 5; r <= 9; r++) begin
      tick();
      seen = seen | ifa.in1 | ifa.chg1;
    end
    check_eq("t5_no_early", 32'(seen), 32'd0);
    tick();
    check_eq("t5_in1_rise", 32'(ifa.in1), 32'd1);
    check_eq("t5_chg1_rise", 32'(ifa.chg1), 32'd1);

    // DEBOUNCE_CYCLES=1: output follows raw two edges later, one strobe per toggle.
    ifa.raw1 = 1'b0;
    ifb.raw1 = 1'b0;
    do_reset();
    hist[0] = 1'b0;
    exp_prev = 1'b0;
    pulses = 0;
    for (int r = 1; r <= 30; r++) begin
      hist[r] = 1'(((r + 2) / 3) % 2);
      ifb.raw1 = hist[r];
      tick();
      exp_out = (r >= 3) ? hist[r-2] : 1'b0;
      check_eq("t6_in1", 32'(ifb.in1), 32'(exp_out));
      check_eq("t6_chg1", 32'(ifb.chg1), 32'(exp_out != exp_prev));
      if (ifb.chg1) pulses++;
      exp_prev = exp_out;
    end
    check_eq("t6_pulses", 32'(pulses), 32'd10);
    check_eq("t6_in2", 32'(ifb.in2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
